// File: rtl/cmt_pkg.sv
// Shared constants for the N-channel compare match timer.
// Register offsets within a channel window, CTRL/STATUS bit positions, CKS
// encodings with their prescaler divisor-minus-one values, and channel stride.
package cmt_pkg;

    // Byte offsets inside one channel's register window
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CNT    = 4'h8;
    localparam logic [3:0] OFF_CONST  = 4'hC;

    // Each channel occupies 16 bytes of address space
    localparam int unsigned CHAN_STRIDE = 32'h10;

    // CTRL bit positions
    localparam int CTRL_STR    = 0;
    localparam int CTRL_CKS_LO = 1;
    localparam int CTRL_CKS_HI = 2;
    localparam int CTRL_CMIE   = 3;
    localparam int CTRL_OS     = 4;

    // STATUS bit positions
    localparam int STATUS_CMF = 0;

    typedef enum logic [1:0] {
        CKS_DIV8   = 2'd0,
        CKS_DIV32  = 2'd1,
        CKS_DIV128 = 2'd2,
        CKS_DIV512 = 2'd3
    } cks_e;

    localparam logic [8:0] DIV8_M1   = 9'd7;
    localparam logic [8:0] DIV32_M1  = 9'd31;
    localparam logic [8:0] DIV128_M1 = 9'd127;
    localparam logic [8:0] DIV512_M1 = 9'd511;

    // Terminal prescaler value for a given clock select
    function automatic logic [8:0] cks_div_m1(input logic [1:0] cks);
        logic [8:0] d;
        case (cks)
            CKS_DIV8:   d = DIV8_M1;
            CKS_DIV32:  d = DIV32_M1;
            CKS_DIV128: d = DIV128_M1;
            default:    d = DIV512_M1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cmt_chan.sv
// One compare-match timer channel: prescaler, up-counter, compare, CTRL/STATUS/CNT/CONST.
// Register writes commit on the strobe edge; compare match sets CMF and irq on the same edge.
// No backpressure: strobes are single-cycle decoded writes that always complete.
//
// Ports: clk/rst (async active-high); ctrl_we/status_we/cnt_we/const_we write strobes with
// wdata; ctrl/cmf/cnt/cnst read-back fields; irq = CMF & CMIE from a flop.
// Build option CMT_ONESHOT_EN: implements the OS bit and one-shot auto-stop; otherwise
// OS reads 0 and the channel is always periodic.
module cmt_chan
    import cmt_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctrl_we,
    input  logic          status_we,
    input  logic          cnt_we,
    input  logic          const_we,
    input  logic [31:0]   wdata,
    output logic [4:0]    ctrl,
    output logic          cmf,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnst,
    output logic          irq
);

    logic          str, str_n;
    logic [1:0]    cks, cks_n;
    logic          cmie, cmie_n;
    logic          cmf_n;
    logic [CW-1:0] cnt_n, cnst_n;
    logic [8:0]    pre, pre_n;
    logic          tick;
    logic          os;
    logic          unused_wdata;

`ifdef CMT_ONESHOT_EN
    logic os_q, os_n;
    assign os = os_q;
`else
    assign os = 1'b0;
`endif

    assign unused_wdata = ^wdata;

    // >= rather than == so a CKS change to a shorter divisor mid-period
    // ticks straight away instead of running the 9-bit prescaler round.
    assign tick = str && (pre >= cks_div_m1(cks));

    always_comb begin
        str_n  = str;
        cks_n  = cks;
        cmie_n = cmie;
        cmf_n  = cmf;
        cnt_n  = cnt;
        cnst_n = cnst;
        pre_n  = '0;
`ifdef CMT_ONESHOT_EN
        os_n   = os_q;
`endif
        // Clear first so a simultaneous match below re-sets the flag
        if (status_we && wdata[STATUS_CMF]) cmf_n = 1'b0;

        if (tick) begin
            if (cnt == cnst) begin
                cnt_n = '0;
                cmf_n = 1'b1;
`ifdef CMT_ONESHOT_EN
                if (os_q) str_n = 1'b0;
`endif
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end

        // Register writes come last so they override same-cycle hardware updates
        if (ctrl_we) begin
            str_n  = wdata[CTRL_STR];
            cks_n  = wdata[CTRL_CKS_HI:CTRL_CKS_LO];
            cmie_n = wdata[CTRL_CMIE];
`ifdef CMT_ONESHOT_EN
            os_n   = wdata[CTRL_OS];
`endif
        end
        if (cnt_we)   cnt_n  = wdata[CW-1:0];
        if (const_we) cnst_n = wdata[CW-1:0];

        // Prescaler only runs across cycles where STR stays high, so the
        // first tick lands exactly one divisor period after a start.
        if (str && str_n) pre_n = tick ? 9'd0 : pre + 9'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            str  <= 1'b0;
            cks  <= 2'd0;
            cmie <= 1'b0;
            cmf  <= 1'b0;
            cnt  <= '0;
            cnst <= '1;
            pre  <= 9'd0;
            irq  <= 1'b0;
`ifdef CMT_ONESHOT_EN
            os_q <= 1'b0;
`endif
        end else begin
            str  <= str_n;
            cks  <= cks_n;
            cmie <= cmie_n;
            cmf  <= cmf_n;
            cnt  <= cnt_n;
            cnst <= cnst_n;
            pre  <= pre_n;
            irq  <= cmf_n & cmie_n;
`ifdef CMT_ONESHOT_EN
            os_q <= os_n;
`endif
        end
    end

    assign ctrl = {os, cmie, cks, str};

endmodule

// File: rtl/cmt_nch.sv
// N-channel compare match timer behind a zero-wait-state APB slave.
// Writes commit on the access edge; reads are combinational in the access phase.
// No backpressure: pready_o is tied high; out-of-range accesses answer with pslverr_o.
//
// Ports: clk/rst (async active-high); APB psel_i/pwrite_i/penable_i/paddr_i/pwdata_i in,
// prdata_o/pslverr_o/pready_o out; cmt_int_o[n] is channel n's registered interrupt.
// Build option CMT_ONESHOT_EN enables the per-channel one-shot mode (see cmt_chan).
module cmt_nch
    import cmt_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CW  = 16,
    parameter int AW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           psel_i,
    input  logic           pwrite_i,
    input  logic           penable_i,
    input  logic [AW-1:0]  paddr_i,
    input  logic [31:0]    pwdata_i,
    output logic [31:0]    prdata_o,
    output logic           pslverr_o,
    output logic           pready_o,
    output logic [NCH-1:0] cmt_int_o
);

    logic [31:0]   addr32;
    logic [31:0]   chan_idx;
    logic [3:0]    off;
    logic          access;
    logic          in_range;
    logic          wr;

    logic [4:0]    ctrl_rd [NCH];
    logic          cmf_rd  [NCH];
    logic [CW-1:0] cnt_rd  [NCH];
    logic [CW-1:0] cnst_rd [NCH];

    assign addr32   = 32'(paddr_i);
    assign chan_idx = addr32 / CHAN_STRIDE;
    assign off      = paddr_i[3:0];
    assign access   = psel_i & penable_i;
    assign in_range = addr32 < NCH * CHAN_STRIDE;
    assign wr       = access & pwrite_i & in_range;

    assign pready_o  = 1'b1;
    assign pslverr_o = access & ~in_range;

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        logic sel;
        assign sel = wr && (chan_idx == 32'(n));

        cmt_chan #(.CW(CW)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .ctrl_we   (sel && off == OFF_CTRL),
            .status_we (sel && off == OFF_STATUS),
            .cnt_we    (sel && off == OFF_CNT),
            .const_we  (sel && off == OFF_CONST),
            .wdata     (pwdata_i),
            .ctrl      (ctrl_rd[n]),
            .cmf       (cmf_rd[n]),
            .cnt       (cnt_rd[n]),
            .cnst      (cnst_rd[n]),
            .irq       (cmt_int_o[n])
        );
    end

    always_comb begin
        prdata_o = 32'd0;
        if (access && !pwrite_i && in_range) begin
            for (int n = 0; n < NCH; n++) begin
                if (chan_idx == 32'(n)) begin
                    case (off)
                        OFF_CTRL:   prdata_o = 32'(ctrl_rd[n]);
                        OFF_STATUS: prdata_o = 32'(cmf_rd[n]);
                        OFF_CNT:    prdata_o = 32'(cnt_rd[n]);
                        OFF_CONST:  prdata_o = 32'(cnst_rd[n]);
                        default:    prdata_o = 32'd0;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/cmt_nch.md
# cmt_nch

Parametrised N-channel compare match timer, the next generation of the two-channel CMT. It is an APB slave on the peripheral bus with NCH independent up-counters. Each counter has its own clock-divider select, compare constant, compare-match flag and interrupt enable. Each channel can run periodic or one-shot, and drives one level interrupt line to the interrupt controller.

## Interface
- NCH, 2: channel count, 1..16
- CW, 16: counter/constant width, 1..32
- AW, 8: APB address width; must satisfy 2^AW ≥ NCH*16
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- psel_i  in  1  APB select
- pwrite_i  in  1  APB write
- penable_i  in  1  APB enable
- paddr_i  in  AW  byte address
- pwdata_i  in  32  write data
- prdata_o  out  32  read data
- pslverr_o  out  1  error response
- pready_o  out  1  ready, tied 1 (zero wait state)
- cmt_int_o  out  NCH  per-channel interrupt, bit n = channel n

## Operation
- Register map, channel n at base n*0x10; fields are zero-extended on read:
  - +0x0 CTRL: [0] STR, [2:1] CKS, [3] CMIE, [4] OS.
  - +0x4 STATUS: [0] CMF. Writing 1 clears it; writing 0 has no effect.
  - +0x8 CNT: [CW-1:0]. Read/write.
  - +0xC CONST: [CW-1:0]. Read/write.
- CKS divisors: 0 = /8, 1 = /32, 2 = /128, 3 = /512.
- Per-channel 9-bit prescaler:
  - Held at 0 while STR = 0.
  - While STR = 1 it increments every clk. When pre == div-1 it wraps to 0 and asserts tick for one cycle.
- On tick with STR = 1:
  - If cnt == CONST: cnt <= 0 and CMF <= 1. If OS = 1, STR <= 0 in the same cycle.
  - Otherwise cnt <= cnt+1, wrapping modulo 2^CW. A wrap does not set CMF.
- STR 1→0 freezes cnt and clears the prescaler. Restarting resumes from the held cnt.
- A CONST or CKS write while running takes effect at the next compare or tick.
- cmt_int_o[n] = CMF[n] & CMIE[n], driven from flops with no combinational path from APB inputs.
- Simultaneous events, per channel:
  - CNT write vs tick: the written value wins.
  - CMF set vs W1C clear in the same cycle: set wins.
  - CTRL write of STR = 1 vs one-shot auto-clear in the same cycle: the written value wins.
- Accesses to unimplemented offsets inside a channel: reads return 0, writes are ignored, pslverr_o = 0.
- Address ≥ NCH*0x10: pslverr_o = 1 in the access phase, writes are ignored, read data is 0.

## Timing
- Write commits on the clk edge where psel_i & penable_i & pwrite_i.
- prdata_o is combinational from the registers while psel_i & penable_i & !pwrite_i, and 0 otherwise.
- Reads have no side effects.
- After the STR write edge, the first tick arrives exactly div clocks later.
- CMF rises (CONST+1)*div clocks after the STR write edge, provided CNT = 0 at start. cmt_int_o rises on the same edge.
- Reset (asynchronous, any time, including mid-count):
  - Registers and prescalers: CTRL = 0, STATUS = 0, CNT = 0, CONST = all ones, prescalers = 0.
  - Outputs: prdata_o = 0, pslverr_o = 0, pready_o = 1, cmt_int_o = 0.

## Configuration
- CMT_ONESHOT_EN defined: the OS bit is implemented and the one-shot auto-stop applies.
- CMT_ONESHOT_EN undefined: the OS bit is not stored, reads as 0, and writes to it are ignored. All channels are periodic.

## Structure
- Package cmt_pkg holds:
  - register offsets (CTRL/STATUS/CNT/CONST)
  - CTRL bit positions
  - CKS encoding and divisor-minus-one constants (7, 31, 127, 511)
  - channel stride 0x10
- Sub-module cmt_chan (parameter CW): one channel's prescaler, counter, compare logic and CTRL/STATUS/CNT/CONST registers.
  - Takes decoded write strobes and data; returns read fields and irq.
  - The top-level cmt_nch generates NCH instances and does the APB decode and read mux.

## Test plan
- Reset: read every register of NCH = 4 → CTRL/STATUS/CNT = 0, CONST = 0xFFFF; pready_o = 1, cmt_int_o = 0.
- Periodic: ch1, CONST = 2, CKS = 0, CMIE = 1, STR = 1 → CMF and cmt_int_o[1] rise 24 clks after the STR write. Write STATUS = 1 → irq drops. CMF sets again 24 clks after the previous match.
- One-shot (CMT_ONESHOT_EN): ch0, CONST = 3, CKS = 1, OS = 1, STR = 1 → after 128 clks CMF = 1, STR reads 0, CNT = 0 and stays 0 for 1000 clks.
- Races:
  - W1C on STATUS in the exact match cycle → CMF stays 1.
  - CNT write of 0x10 on a tick cycle → CNT reads 0x10.
- Wrap: CNT = 0xFFFE, CONST = 1, CKS = 0 → CNT goes 0xFFFF → 0 → 1, with CMF at the tick after reaching 1 and no CMF at the wrap.
- Errors and reset mid-op:
  - Access to 0x40 with NCH = 4 → pslverr_o = 1, prdata_o = 0, no state change.
  - rst pulse while ch0 is counting → all state returns to reset values immediately.
